// File: rtl/jump_alu_unit_if.sv
// Operand/result bundle for jump_alu_unit: the master drives the operands, the slave returns the registered target.
interface jump_alu_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] inputPC;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] jump_target;
  logic             out_valid;
  logic             wrap;
  logic             misaligned;

  modport master (
    output in_valid, inputPC, offset,
    input  jump_target, out_valid, wrap, misaligned
  );

  modport slave (
    input  in_valid, inputPC, offset,
    output jump_target, out_valid, wrap, misaligned
  );
endinterface

// File: rtl/jump_alu_unit.sv
// Branch/jump target adder: jump_target = inputPC + (offset << OFFSET_SHIFT), registered with valid and wrap flags.
// Optional alignment check is compiled in with `define JUMP_ALU_ALIGN_CHECK_EN.
module jump_alu_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned OFFSET_SHIFT = 0,
  parameter int unsigned ALIGN_BITS   = 2
) (
  input logic           clk,
  input logic           rst_n,
  jump_alu_unit_if.slave bus
);

  if (ALIGN_BITS > WIDTH) begin : g_bad_align
    $error("jump_alu_unit: ALIGN_BITS must not exceed WIDTH");
  end

  logic [WIDTH-1:0] eff;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             wrap_calc;

  assign eff            = bus.offset << OFFSET_SHIFT;
  assign {carry, sum}   = {1'b0, bus.inputPC} + {1'b0, eff};
  // Carry without a negative offset is a forward wrap; a negative offset without carry is a backward wrap.
  assign wrap_calc      = carry ^ eff[WIDTH-1];

  logic [WIDTH-1:0] target_q, target_d;
  logic             valid_q,  valid_d;
  logic             wrap_q,   wrap_d;

  always_comb begin
    target_d = target_q;
    wrap_d   = wrap_q;
    valid_d  = bus.in_valid;
    if (bus.in_valid) begin
      target_d = sum;
      wrap_d   = wrap_calc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.jump_target = target_q;
  assign bus.out_valid   = valid_q;
  assign bus.wrap        = wrap_q;

`ifdef JUMP_ALU_ALIGN_CHECK_EN
  logic mis_calc;
  logic mis_q, mis_d;

  if (ALIGN_BITS == 0) begin : g_no_align
    assign mis_calc = 1'b0;
  end else begin : g_align
    assign mis_calc = |sum[ALIGN_BITS-1:0];
  end

  always_comb begin
    mis_d = mis_q;
    if (bus.in_valid) mis_d = mis_calc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end

  assign bus.misaligned = mis_q;
`else
  assign bus.misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_jump_alu_unit.sv
// Scoreboard bench for jump_alu_unit: one instance with byte offsets, one with word offsets (OFFSET_SHIFT=2).
module tb_jump_alu_unit;

  typedef struct packed {
    logic [31:0] tgt;
    logic        wrap;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  exp_t q0[$];
  exp_t q2[$];
  exp_t last0, last2;

  jump_alu_unit_if #(.WIDTH(32)) if0 ();
  jump_alu_unit_if #(.WIDTH(32)) if2 ();

  jump_alu_unit #(.WIDTH(32), .OFFSET_SHIFT(0), .ALIGN_BITS(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  jump_alu_unit #(.WIDTH(32), .OFFSET_SHIFT(2), .ALIGN_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic; wrap means the true result left [0, 2^32).
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] off, input int sh);
    logic [31:0] eff;
    longint      r;
    exp_t        e;
    eff    = off << sh;
    r      = longint'({32'd0, pc}) + longint'($signed(eff));
    e.tgt  = r[31:0];
    e.wrap = (r < 0) || (r > 64'sd4294967295);
`ifdef JUMP_ALU_ALIGN_CHECK_EN
    e.mis  = (e.tgt % 4) != 0;
`else
    e.mis  = 1'b0;
`endif
    return e;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_tgt0"}, if0.jump_target, 0);
    check({tag, "_val0"}, if0.out_valid, 0);
    check({tag, "_wrap0"}, if0.wrap, 0);
    check({tag, "_mis0"}, if0.misaligned, 0);
    check({tag, "_tgt2"}, if2.jump_target, 0);
    check({tag, "_val2"}, if2.out_valid, 0);
    check({tag, "_wrap2"}, if2.wrap, 0);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] off);
    if0.in_valid = v; if0.inputPC = pc; if0.offset = off;
    if2.in_valid = v; if2.inputPC = pc; if2.offset = off;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] off);
    exp_t e;
    drive(1'b1, pc, off);
    q0.push_back(model(pc, off, 0));
    q2.push_back(model(pc, off, 2));
    @(posedge clk); #1;
    check("val0", if0.out_valid, 1);
    if (if0.out_valid && q0.size() > 0) begin
      e = q0.pop_front();
      check("tgt0", if0.jump_target, e.tgt);
      check("wrap0", if0.wrap, e.wrap);
      check("mis0", if0.misaligned, e.mis);
      last0 = e;
    end
    check("val2", if2.out_valid, 1);
    if (if2.out_valid && q2.size() > 0) begin
      e = q2.pop_front();
      check("tgt2", if2.jump_target, e.tgt);
      check("wrap2", if2.wrap, e.wrap);
      check("mis2", if2.misaligned, e.mis);
      last2 = e;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, $urandom, $urandom);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b1, $urandom, $urandom);
    end
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, '0);
    @(posedge clk); #1;

    // Directed vectors, back to back.
    send(32'h0000_000E, 32'h0000_0001);
    check("fwd_const", if0.jump_target, 32'h0000_000F);
    send(32'h0000_000E, 32'hFFFF_FFFF);
    check("neg_const", if0.jump_target, 32'h0000_000D);
    send(32'h0000_0000, 32'hFFFF_FFFF);
    check("bwrap_const", if0.wrap, 1);
    send(32'hFFFF_FFFF, 32'h0000_0001);
    check("fwrap_tgt", if0.jump_target, 32'h0000_0000);
    check("fwrap_const", if0.wrap, 1);
    send(32'h0000_1234, 32'h0000_0000);
    check("zero_off", if0.jump_target, 32'h0000_1234);
    send(32'h8000_0000, 32'h7FFF_FFFF);
    send(32'h0000_0100, 32'h0000_0002);
    send(32'h0000_0100, 32'h0000_0004);
    send(32'h4000_0000, 32'h3000_0000);
    send(32'h0000_0100, 32'h0000_0003);
    check("shift_const", if2.jump_target, 32'h0000_010C);

    // Hold: in_valid low with fresh operands.
    drive(1'b0, 32'hDEAD_BEEF, 32'h1234_5677);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("hold_val0", if0.out_valid, 0);
      check("hold_tgt0", if0.jump_target, last0.tgt);
      check("hold_wrap0", if0.wrap, last0.wrap);
      check("hold_mis0", if0.misaligned, last0.mis);
      check("hold_val2", if2.out_valid, 0);
      check("hold_tgt2", if2.jump_target, 32'h0000_010C);
      check("hold_wrap2", if2.wrap, last2.wrap);
    end

    for (int i = 0; i < 24; i++) begin
      send($urandom, (i % 3 == 0) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom);
    end

    // Asynchronous reset between edges clears outputs at once.
    send(32'hFFFF_FFF0, 32'h0000_0031);
    #3 rst_n = 1'b0;
    #1 check_zero("arst");
    q0.delete();
    q2.delete();
    #2 rst_n = 1'b1;
    drive(1'b0, $urandom, $urandom);
    @(posedge clk); #1;
    check_zero("post_arst");

    send(32'h0000_0000, 32'hFFFF_FFFC);
    send(32'h7FFF_FFFF, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
